// File: rtl/sdf_pkg.sv
// Shared types and constants for the radix-2 single-path delay-feedback stage.
// Optional build macro: SDF_ROUND_EN (round half up on the twiddle product).
package sdf_pkg;

  localparam int DATA_W = 24;
  localparam int FRAC_W = 8;
  localparam int DEPTH  = 16;
  localparam int PTR_W  = $clog2(DEPTH);

  // Phase supplied by the twiddle ROM alongside each sample
  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_BF   = 2'd1,
    ST_TW   = 2'd2,
    ST_ILL  = 2'd3
  } sdf_state_e;

  // One complex Q15.8 sample
  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

endpackage

// File: rtl/radix2_sdf_stage16_if.sv
// Sample/twiddle input bundle and registered output bundle of the SDF stage.
interface radix2_sdf_stage16_if;
  import sdf_pkg::*;

  logic                     in_valid;
  logic [1:0]               state;
  logic signed [DATA_W-1:0] din_r;
  logic signed [DATA_W-1:0] din_i;
  logic signed [DATA_W-1:0] w_r;
  logic signed [DATA_W-1:0] w_i;
  logic                     out_valid;
  logic signed [DATA_W-1:0] dout_r;
  logic signed [DATA_W-1:0] dout_i;

  modport master (
    output in_valid, state, din_r, din_i, w_r, w_i,
    input  out_valid, dout_r, dout_i
  );

  modport slave (
    input  in_valid, state, din_r, din_i, w_r, w_i,
    output out_valid, dout_r, dout_i
  );
endinterface

// File: rtl/sdf_delay_line.sv
// DEPTH-entry complex circular buffer. The entry under the pointer is both
// the head (oldest sample) that is read and the slot overwritten on an
// enabled cycle, so one pointer gives an exact DEPTH-push delay.
module sdf_delay_line
  import sdf_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  cplx_t wdata,
  output cplx_t rdata
);

  cplx_t            mem_r [DEPTH];
  logic [PTR_W-1:0] ptr_r;

  assign rdata = mem_r[ptr_r];

  // Pointer advance with circular wrap; only the pointer is reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r <= {PTR_W{1'b0}};
    end else if (en) begin
      if (ptr_r == PTR_W'(DEPTH - 1)) begin
        ptr_r <= {PTR_W{1'b0}};
      end else begin
        ptr_r <= ptr_r + PTR_W'(1);
      end
    end
  end

  // Storage write; contents are unreset because fill overwrites every slot
  always_ff @(posedge clk) begin
    if (en) begin
      mem_r[ptr_r] <= wdata;
    end
  end

endmodule

// File: rtl/radix2_sdf_stage16.sv
// Radix-2 SDF butterfly stage with a 16-deep feedback delay and a registered
// complex twiddle multiply. Build macro SDF_ROUND_EN selects round-half-up
// on the product; otherwise the product is truncated (floor).
module radix2_sdf_stage16
  import sdf_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  radix2_sdf_stage16_if.slave bus
);

  localparam int PROD_W = 2 * DATA_W;

`ifdef SDF_ROUND_EN
  localparam logic signed [PROD_W-1:0] RND = 48'sd128;
`else
  localparam logic signed [PROD_W-1:0] RND = 48'sd0;
`endif

  cplx_t head_s;
  cplx_t din_s;
  cplx_t wdata_s;
  cplx_t mul_a_s;
  logic  out_en_s;

  logic signed [PROD_W-1:0] ar_s, ai_s, wr_s, wi_s;
  logic signed [PROD_W-1:0] pr_s, pi_s;

  logic                     out_valid_r;
  logic signed [DATA_W-1:0] dout_r_r;
  logic signed [DATA_W-1:0] dout_i_r;

  assign din_s.re = bus.din_r;
  assign din_s.im = bus.din_i;

  sdf_delay_line u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.in_valid),
    .wdata (wdata_s),
    .rdata (head_s)
  );

  // Butterfly: choose what is fed back into the delay and what is multiplied
  always_comb begin
    wdata_s  = din_s;
    mul_a_s  = head_s;
    out_en_s = 1'b0;
    case (sdf_state_e'(bus.state))
      ST_BF: begin
        wdata_s.re = head_s.re - din_s.re;
        wdata_s.im = head_s.im - din_s.im;
        mul_a_s.re = head_s.re + din_s.re;
        mul_a_s.im = head_s.im + din_s.im;
        out_en_s   = 1'b1;
      end
      ST_TW: begin
        out_en_s = 1'b1;
      end
      default: begin
        out_en_s = 1'b0;
      end
    endcase
  end

  // Full-precision complex multiply; wrap is intentional in the low bits
  always_comb begin
    ar_s = PROD_W'(mul_a_s.re);
    ai_s = PROD_W'(mul_a_s.im);
    wr_s = PROD_W'(bus.w_r);
    wi_s = PROD_W'(bus.w_i);
    pr_s = ar_s * wr_s - ai_s * wi_s + RND;
    pi_s = ar_s * wi_s + ai_s * wr_s + RND;
  end

  // Output register: strobe only for accepted butterfly/twiddle samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      dout_r_r    <= '0;
      dout_i_r    <= '0;
    end else if (bus.in_valid) begin
      out_valid_r <= out_en_s;
      if (out_en_s) begin
        dout_r_r <= pr_s[FRAC_W +: DATA_W];
        dout_i_r <= pi_s[FRAC_W +: DATA_W];
      end
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.dout_r    = dout_r_r;
  assign bus.dout_i    = dout_i_r;

endmodule

// File: tb/tb_radix2_sdf_stage16.sv
// Self-checking bench for radix2_sdf_stage16: an independent queue-based
// delay model predicts each output, expectations go through a scoreboard.
module tb_radix2_sdf_stage16;
  import sdf_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  radix2_sdf_stage16_if bus ();

  radix2_sdf_stage16 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic signed [23:0] mq_r[$];
  logic signed [23:0] mq_i[$];
  logic [47:0]        exp_q[$];
  logic [47:0]        last_out;
  logic signed [23:0] a_r[16];
  logic signed [23:0] a_i[16];
  int                 cos_t[9] = '{256, 251, 237, 213, 181, 142, 98, 50, 0};

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] scale(input longint p);
    longint q;
    q = p;
`ifdef SDF_ROUND_EN
    q = q + 64'sd128;
`endif
    q = q >>> 8;
    return q[23:0];
  endfunction

  // Twiddle W^k for a 32-point DIF first stage, scaled by 256
  task automatic rom(input int k, output logic signed [23:0] wr, output logic signed [23:0] wi);
    if (k <= 8) begin
      wr = 24'(cos_t[k]);
      wi = -24'(cos_t[8 - k]);
    end else begin
      wr = -24'(cos_t[16 - k]);
      wi = -24'(cos_t[k - 8]);
    end
  endtask

  task automatic step(input bit v, input logic [1:0] st, input logic signed [23:0] dr,
                      input logic signed [23:0] di, input logic signed [23:0] wr,
                      input logic signed [23:0] wi);
    logic signed [23:0] hr, hi, ar, ai, pr_, pi_;
    bit ev;
    ev = 1'b0;
    bus.in_valid = v; bus.state = st;
    bus.din_r = dr; bus.din_i = di; bus.w_r = wr; bus.w_i = wi;
    if (v) begin
      hr = (mq_r.size() == 16) ? mq_r[0] : 24'sd0;
      hi = (mq_i.size() == 16) ? mq_i[0] : 24'sd0;
      if (mq_r.size() == 16) begin
        void'(mq_r.pop_front());
        void'(mq_i.pop_front());
      end
      if (st == 2'd1) begin
        ar = hr + dr; ai = hi + di;
        mq_r.push_back(hr - dr); mq_i.push_back(hi - di);
      end else begin
        ar = hr; ai = hi;
        mq_r.push_back(dr); mq_i.push_back(di);
      end
      if (st == 2'd1 || st == 2'd2) begin
        ev = 1'b1;
        pr_ = scale(longint'(ar) * longint'(wr) - longint'(ai) * longint'(wi));
        pi_ = scale(longint'(ar) * longint'(wi) + longint'(ai) * longint'(wr));
        exp_q.push_back({pr_, pi_});
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", {47'd0, bus.out_valid}, {47'd0, ev});
    if (ev) begin
      last_out = exp_q.pop_front();
      chk("dout", {bus.dout_r, bus.dout_i}, last_out);
    end else if (!v) begin
      chk("hold", {bus.dout_r, bus.dout_i}, last_out);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.state = 2'd0;
    bus.din_r = '0; bus.din_i = '0; bus.w_r = '0; bus.w_i = '0;
    mq_r.delete(); mq_i.delete(); exp_q.delete();
    @(posedge clk);
    #1;
    chk("rst_valid", {47'd0, bus.out_valid}, 48'd0);
    chk("rst_dout", {bus.dout_r, bus.dout_i}, 48'd0);
    last_out = 48'd0;
    rst_n = 1'b1;
  endtask

  task automatic fill_a(input logic signed [23:0] r, input logic signed [23:0] i);
    for (int k = 0; k < 16; k++) begin
      a_r[k] = r; a_i[k] = i;
    end
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 16; k++) begin
      a_r[k] = 24'($urandom); a_i[k] = 24'($urandom);
    end
  endtask

  // One 16-sample segment of the given phase, ROM twiddles
  task automatic seg(input logic [1:0] st);
    logic signed [23:0] wr, wi;
    for (int k = 0; k < 16; k++) begin
      if (st == 2'd2) rom(k, wr, wi);
      else begin wr = 24'sd256; wi = 24'sd0; end
      step(1'b1, st, a_r[k], a_i[k], wr, wi);
    end
  endtask

  task automatic dc_frame();
    fill_a(24'sd100, 24'sd0);
    seg(2'd0);
    seg(2'd1);
    chk("dc_sum", last_out, {24'd200, 24'd0});
    seg(2'd2);
    chk("dc_diff", last_out, 48'd0);
    seg(2'd1);
    chk("dc_sum2", last_out, {24'd200, 24'd0});
  endtask

  initial begin
    logic signed [23:0] wr, wi;
    last_out = 48'd0;
    do_reset();
    do_reset();

    // DC frame with continuous 1->2->1 alternation
    dc_frame();

    // Twiddle visibility
    do_reset();
    fill_a(24'sd256, 24'sd0); seg(2'd0);
    fill_a(24'sd0, 24'sd0);   seg(2'd1);
    for (int k = 0; k < 16; k++) begin
      rom(k, wr, wi);
      step(1'b1, 2'd2, 24'sd0, 24'sd0, wr, wi);
      if (k == 4) chk("tw_k4", {bus.dout_r, bus.dout_i}, {24'd181, 24'hFFFF4B});
      if (k == 8) chk("tw_k8", {bus.dout_r, bus.dout_i}, {24'd0, 24'hFFFF00});
    end

    // Rounding of head (1,0) times (181,-181)
    do_reset();
    fill_a(24'sd0, 24'sd0); a_r[0] = 24'sd1; seg(2'd0);
    fill_a(24'sd0, 24'sd0); seg(2'd1);
    step(1'b1, 2'd2, 24'sd0, 24'sd0, 24'sd181, -24'sd181);
`ifdef SDF_ROUND_EN
    chk("round", {bus.dout_r, bus.dout_i}, {24'd1, 24'hFFFFFF});
`else
    chk("round", {bus.dout_r, bus.dout_i}, {24'd0, 24'hFFFFFF});
`endif

    // Overflow wrap in the butterfly adder
    do_reset();
    fill_a(24'sd0, 24'sd0); a_r[0] = 24'sh7FFFFF; seg(2'd0);
    step(1'b1, 2'd1, 24'sd1, 24'sd0, 24'sd256, 24'sd0);
    chk("ovf", {24'd0, bus.dout_r}, {24'd0, 24'h800000});

    // Stall of 3 cycles mid-butterfly, then finish the frame
    do_reset();
    fill_rand(); seg(2'd0);
    fill_rand();
    for (int k = 0; k < 16; k++) begin
      if (k == 8) for (int s = 0; s < 3; s++) step(1'b0, 2'd1, 24'sd5, 24'sd5, 24'sd256, 24'sd0);
      step(1'b1, 2'd1, a_r[k], a_i[k], 24'sd256, 24'sd0);
    end
    fill_rand(); seg(2'd2);

    // Illegal phase during fill behaves as fill
    do_reset();
    fill_rand();
    for (int k = 0; k < 16; k++)
      step(1'b1, (k % 2 == 1) ? 2'd3 : 2'd0, a_r[k], a_i[k], 24'sd256, 24'sd0);
    fill_rand(); seg(2'd1);
    fill_rand(); seg(2'd2);

    // Reset part way into a frame, then a clean DC frame
    do_reset();
    fill_a(24'sd100, 24'sd0); seg(2'd0);
    for (int k = 0; k < 4; k++) step(1'b1, 2'd1, 24'sd100, 24'sd0, 24'sd256, 24'sd0);
    do_reset();
    dc_frame();

    // Random continuous frames with random twiddles and sporadic stalls
    do_reset();
    fill_rand(); seg(2'd0);
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 16; k++) begin
        if ($urandom_range(0, 7) == 0) step(1'b0, 2'd2, 24'sd0, 24'sd0, 24'sd0, 24'sd0);
        step(1'b1, 2'd1, 24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom));
      end
      for (int k = 0; k < 16; k++)
        step(1'b1, 2'd2, 24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
